// File: rtl/weight_readout.sv
// Host read port for the on-chip trainer. On a host request it snapshots the
// trained weights and the latest output-neuron result, then streams them as a
// fixed 15-byte frame (header, payload, XOR checksum) over an 8-bit bus.
//
// Handshake (4-phase, host pins are asynchronous and synchronized first):
//   valid_o rises with a stable data_o/last_o; the host raises ack_i once it
//   has taken the byte; valid_o then drops; the host drops ack_i; only then is
//   the next byte presented. Dropping req_i at any point before the frame is
//   finished aborts it; after the last byte frame_done_o holds until req_i
//   drops.
module weight_readout #(
  parameter int          SYNC_STAGES = 2,     // flops per host-pin synchronizer, at least 2
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] hn0_weights_i,
  input  logic [31:0] hn1_weights_i,
  input  logic [15:0] on_weights_i,
  input  logic [18:0] final_i,
  input  logic        busy_i,
  input  logic        req_i,
  input  logic        ack_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        last_o,
  output logic        frame_done_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNAP    = 3'd1,
    PRESENT = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd14;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   req_s;
  logic                   ack_s;
  logic [3:0]             byte_idx;
  logic [3:0]             next_idx;
  logic [7:0]             checksum;
  logic [7:0]             next_byte;
  logic [31:0]            snap_hn0;
  logic [31:0]            snap_hn1;
  logic [15:0]            snap_on;
  logic [18:0]            snap_final;
  logic [23:0]            final_ext;

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign final_ext = {5'd0, snap_final};
  assign state_o   = state;

  // The index never wraps: once at the checksum byte it stays there.
  assign next_idx = (byte_idx == LAST_IDX) ? LAST_IDX : byte_idx + 4'd1;

  // Bring the asynchronous host pins into the clock domain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  // Select the frame byte that follows the current one, from the snapshot.
  always_comb begin
    next_byte = 8'h00;
    case (next_idx)
      4'd0:    next_byte = HEADER;
      4'd1:    next_byte = snap_hn0[7:0];
      4'd2:    next_byte = snap_hn0[15:8];
      4'd3:    next_byte = snap_hn0[23:16];
      4'd4:    next_byte = snap_hn0[31:24];
      4'd5:    next_byte = snap_hn1[7:0];
      4'd6:    next_byte = snap_hn1[15:8];
      4'd7:    next_byte = snap_hn1[23:16];
      4'd8:    next_byte = snap_hn1[31:24];
      4'd9:    next_byte = snap_on[7:0];
      4'd10:   next_byte = snap_on[15:8];
      4'd11:   next_byte = final_ext[7:0];
      4'd12:   next_byte = final_ext[15:8];
      4'd13:   next_byte = final_ext[23:16];
      4'd14:   next_byte = checksum;
      default: next_byte = 8'h00;
    endcase
  end

  // Frame sequencer: snapshot, then one 4-phase handshake per byte.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      frame_done_o <= 1'b0;
      byte_idx     <= 4'd0;
      checksum     <= 8'h00;
      snap_hn0     <= '0;
      snap_hn1     <= '0;
      snap_on      <= '0;
      snap_final   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s && !busy_i) state <= SNAP;
        end

        SNAP: begin
          if (!req_s) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            byte_idx <= 4'd0;
          end else begin
            snap_hn0   <= hn0_weights_i;
            snap_hn1   <= hn1_weights_i;
            snap_on    <= on_weights_i;
            snap_final <= final_i;
            checksum   <= 8'h00;
            // A host ack still high from a previous exchange must clear first.
            if (!ack_s) begin
              state    <= PRESENT;
              byte_idx <= 4'd0;
              data_o   <= HEADER;
              last_o   <= 1'b0;
              valid_o  <= 1'b1;
            end
          end
        end

        PRESENT: begin
          // An abort takes precedence over an ack seen in the same cycle.
          if (!req_s) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            byte_idx <= 4'd0;
          end else if (ack_s) begin
            checksum <= checksum ^ data_o;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            state    <= RELEASE;
          end
        end

        RELEASE: begin
          if (!req_s) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            byte_idx <= 4'd0;
          end else if (!ack_s) begin
            if (byte_idx == LAST_IDX) begin
              frame_done_o <= 1'b1;
              state        <= DONE;
            end else begin
              byte_idx <= next_idx;
              data_o   <= next_byte;
              last_o   <= (next_idx == LAST_IDX);
              valid_o  <= 1'b1;
              state    <= PRESENT;
            end
          end
        end

        DONE: begin
          if (!req_s) begin
            frame_done_o <= 1'b0;
            byte_idx     <= 4'd0;
            state        <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          valid_o  <= 1'b0;
          last_o   <= 1'b0;
          byte_idx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_readout.sv
// Directed bench for weight_readout: reset values, full frames, busy gating,
// stale ack, abort and reset in the middle of a frame.
module tb_weight_readout;

  logic        clk;
  logic        rst_i;
  logic [31:0] hn0_weights_i;
  logic [31:0] hn1_weights_i;
  logic [15:0] on_weights_i;
  logic [18:0] final_i;
  logic        busy_i;
  logic        req_i;
  logic        ack_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;
  logic        frame_done_o;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  weight_readout #(.SYNC_STAGES(2), .HEADER(8'hA5)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .hn0_weights_i (hn0_weights_i),
    .hn1_weights_i (hn1_weights_i),
    .on_weights_i  (on_weights_i),
    .final_i       (final_i),
    .busy_i        (busy_i),
    .req_i         (req_i),
    .ack_i         (ack_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .frame_done_o  (frame_done_o),
    .state_o       (state_o)
  );

  // Clock and safety watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until valid_o (sel=0) or frame_done_o (sel=1) reaches level.
  task automatic wait_level(input string tag, input int sel, input logic level, input int max);
    int n;
    logic sig;
    n = 0;
    sig = (sel == 0) ? valid_o : frame_done_o;
    while (n < max && sig !== level) begin
      @(negedge clk);
      n++;
      sig = (sel == 0) ? valid_o : frame_done_o;
    end
    if (sig !== level) check({tag, "_timeout"}, {31'd0, sig}, {31'd0, level});
  endtask

  // One full 4-phase exchange for a byte; expected byte from the queue.
  task automatic read_byte(input string tag, input int idx);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    wait_level($sformatf("%s_v%0d", tag, idx), 0, 1'b1, 100);
    check($sformatf("%s_byte%0d", tag, idx), {24'd0, data_o}, {24'd0, exp});
    check($sformatf("%s_last%0d", tag, idx), {31'd0, last_o}, {31'd0, (idx == 14)});
    ack_i = 1'b1;
    wait_level($sformatf("%s_vdrop%0d", tag, idx), 0, 1'b0, 100);
    check($sformatf("%s_hold%0d", tag, idx), {24'd0, data_o}, {24'd0, exp});
    ack_i = 1'b0;
  endtask

  task automatic read_bytes(input string tag, input int first, input int count);
    for (int i = 0; i < count; i++) read_byte(tag, first + i);
  endtask

  task automatic finish_frame(input string tag);
    wait_level({tag, "_done"}, 1, 1'b1, 100);
    check({tag, "_done_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_done_last"}, {31'd0, last_o}, 32'd0);
    repeat (5) @(negedge clk);
    check({tag, "_done_held"}, {31'd0, frame_done_o}, 32'd1);
    req_i = 1'b0;
    wait_level({tag, "_done_clr"}, 1, 1'b0, 6);
    repeat (4) @(negedge clk);
    check({tag, "_idle"}, {29'd0, state_o}, 32'd0);
  endtask

  task automatic set_frame_a();
    hn0_weights_i = 32'h04030201;
    hn1_weights_i = 32'h04030201;
    on_weights_i  = 16'h0201;
    final_i       = 19'h00012;
  endtask

  task automatic set_frame_b();
    hn0_weights_i = 32'h11223344;
    hn1_weights_i = 32'hA0B0C0D0;
    on_weights_i  = 16'h5566;
    final_i       = 19'h7ABCD;
  endtask

  // Directed sequence
  initial begin
    int bad;
    rst_i  = 1'b0;
    busy_i = 1'b0;
    req_i  = 1'b0;
    ack_i  = 1'b0;
    set_frame_a();

    // Reset with random inputs and random host pins
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hn0_weights_i = $urandom;
      hn1_weights_i = $urandom;
      on_weights_i  = 16'($urandom);
      final_i       = 19'($urandom);
      busy_i        = 1'($urandom_range(0, 1));
      req_i         = 1'($urandom_range(0, 1));
      ack_i         = 1'($urandom_range(0, 1));
    end
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_last", {31'd0, last_o}, 32'd0);
    check("rst_done", {31'd0, frame_done_o}, 32'd0);
    check("rst_state", {29'd0, state_o}, 32'd0);

    @(negedge clk);
    req_i  = 1'b0;
    ack_i  = 1'b0;
    busy_i = 1'b0;
    set_frame_a();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    check("post_rst_data", {24'd0, data_o}, 32'd0);
    check("post_rst_done", {31'd0, frame_done_o}, 32'd0);

    // Full frame A, with latency from req_i to valid_o
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03,
              8'h04, 8'h01, 8'h02, 8'h12, 8'h00, 8'h00, 8'hB4};
    req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lat_early", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'd0, valid_o}, 32'd1);
    check("lat_header", {24'd0, data_o}, 32'h000000A5);
    @(negedge clk);
    read_bytes("fa", 0, 15);
    finish_frame("fa");

    // Busy gating, then weight changes during the transfer
    set_frame_b();
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hD0, 8'hC0, 8'hB0,
              8'hA0, 8'h66, 8'h55, 8'hCD, 8'hAB, 8'h07, 8'hB3};
    busy_i = 1'b1;
    req_i  = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_hold_valid", {31'd0, valid_o}, 32'd0);
    check("busy_hold_state", {29'd0, state_o}, 32'd0);
    busy_i = 1'b0;
    @(posedge clk);
    #1;
    check("busy_snap_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    check("busy_rel_valid", {31'd0, valid_o}, 32'd1);
    @(negedge clk);
    read_bytes("fb", 0, 1);
    hn0_weights_i = 32'hDEADBEEF;
    hn1_weights_i = 32'h0BADF00D;
    on_weights_i  = 16'hFFFF;
    final_i       = 19'h55555;
    busy_i        = 1'b1;
    read_bytes("fb", 1, 14);
    finish_frame("fb");
    busy_i = 1'b0;

    // Stale ack, then abort after byte 5 is acknowledged
    hn0_weights_i = 32'hCAFEF00D;
    hn1_weights_i = 32'h12345678;
    exp_q = '{8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    ack_i = 1'b1;
    req_i = 1'b1;
    repeat (10) @(negedge clk);
    check("stale_valid", {31'd0, valid_o}, 32'd0);
    ack_i = 1'b0;
    read_bytes("st", 0, 5);
    wait_level("st_v5", 0, 1'b1, 100);
    check("st_byte5", {24'd0, data_o}, 32'h00000078);
    ack_i = 1'b1;
    wait_level("st_vdrop5", 0, 1'b0, 100);
    req_i = 1'b0;
    ack_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || frame_done_o !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 32'd0);
    check("abort_state", {29'd0, state_o}, 32'd0);
    check("abort_data_hold", {24'd0, data_o}, 32'h00000078);

    // New request after abort restarts at the header
    set_frame_a();
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03,
              8'h04, 8'h01, 8'h02, 8'h12, 8'h00, 8'h00, 8'hB4};
    req_i = 1'b1;
    read_bytes("ra", 0, 15);
    finish_frame("ra");

    // Reset while byte 7 is presented
    set_frame_b();
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hD0, 8'hC0};
    req_i = 1'b1;
    read_bytes("mr", 0, 7);
    wait_level("mr_v7", 0, 1'b1, 100);
    check("mr_byte7", {24'd0, data_o}, 32'h000000B0);
    #2;
    rst_i = 1'b0;
    #1;
    check("mr_valid", {31'd0, valid_o}, 32'd0);
    check("mr_data", {24'd0, data_o}, 32'd0);
    check("mr_state", {29'd0, state_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hD0, 8'hC0, 8'hB0,
              8'hA0, 8'h66, 8'h55, 8'hCD, 8'hAB, 8'h07, 8'hB3};
    req_i = 1'b1;
    read_bytes("mb", 0, 15);
    finish_frame("mb");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_readout.md
Name: weight_readout

Overview:
- Host-facing read port for the on-chip trainer.
- On host request, takes an atomic snapshot of all trained weights and the latest output-neuron result.
- Streams the snapshot as a fixed 15-byte frame over an 8-bit bus using a 4-phase valid/ack handshake.
- Sits beside the training state machine. The backprop units write the weights; this block reads them out to the pins.

Parameters:
- SYNC_STAGES, 2, number of flops in each synchronizer for the asynchronous host pins req_i and ack_i (minimum 2).
- HEADER, 8'hA5, constant first byte of every frame.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- hn0_weights_i  in  32  hidden neuron 0 weights {w3,w2,w1,w0}
- hn1_weights_i  in  32  hidden neuron 1 weights {w3,w2,w1,w0}
- on_weights_i  in  16  output neuron weights {w1,w0}
- final_i  in  19  output neuron result
- busy_i  in  1  high while a forward or backward pass is running; snapshot is not allowed
- req_i  in  1  host read request, asynchronous pin, level
- ack_i  in  1  host byte acknowledge, asynchronous pin, level
- data_o  out  8  frame byte
- valid_o  out  1  data_o is valid
- last_o  out  1  data_o is the final (checksum) byte
- frame_done_o  out  1  frame fully transferred; held until req is released

Behaviour:
- Reset (rst_i low, async): state IDLE; data_o=0, valid_o=0, last_o=0, frame_done_o=0; byte index=0; checksum=0; snapshot registers=0; synchronizers cleared to 0.
- req_i and ack_i pass through SYNC_STAGES flops before use (req_s, ack_s). No other logic samples the raw pins.
- Frame layout, byte index 0..14:
  - 0: HEADER
  - 1-4: hn0_weights bytes, LSB first
  - 5-8: hn1_weights bytes, LSB first
  - 9-10: on_weights bytes, LSB first
  - 11-13: final zero-extended to 24 bits, LSB first
  - 14: XOR of bytes 0-13
- States:
  - IDLE: if req_s=1 and busy_i=0, go to SNAP. If req_s=1 and busy_i=1, stay in IDLE until busy_i drops.
  - SNAP: one cycle. Latch all four data inputs into snapshot registers and clear checksum. If ack_s=0, go to PRESENT; otherwise stay until ack_s=0 (protects against a stale host ack).
  - PRESENT: valid_o=1 and data_o=byte[index]; last_o=1 only when index=14. On ack_s=1: XOR data_o into checksum, drop valid_o, go to RELEASE.
  - RELEASE: valid_o=0. On ack_s=0: if index=14, go to DONE; otherwise index+1 and go to PRESENT.
  - DONE: frame_done_o=1. On req_s=0: clear frame_done_o and index, go to IDLE.
- Output timing:
  - data_o and last_o are registered and stable for the whole time valid_o is high.
  - data_o holds its last value when valid_o is low.
- Latency: req_i rising with busy_i low -> valid_o high exactly SYNC_STAGES+2 clk_i edges later (if ack_i is low).
- Abort: req_s=0 in SNAP, PRESENT or RELEASE -> next cycle valid_o=0, last_o=0, index=0, state IDLE. No frame_done_o is produced.
- busy_i is ignored after SNAP. The snapshot is immune to weight updates during a transfer.
- Simultaneous ack_s rise and req_s fall in PRESENT: the abort wins.
- Index wrap never occurs; the index saturates at 14.
- Reset mid-frame: immediate return to the reset values; the host must restart.

Test Plan:
- Reset values: rst_i low with random inputs and random req/ack -> all outputs 0. Release reset with req_i=0 -> outputs stay 0.
- Full frame: hn0=32'h04030201, hn1=32'h04030201, on=16'h0201, final=19'h00012; host does a 4-phase handshake per byte.
  - Bytes must be A5,01,02,03,04,01,02,03,04,01,02,12,00,00,B4.
  - last_o high only on B4; frame_done_o high after the final ack drop until req_i falls.
- Busy gating: busy_i=1 while req_i rises -> valid_o stays 0. Drop busy_i -> valid_o rises SNAP+1 cycles later. Change the weight inputs mid-frame -> the streamed bytes still match the snapshot.
- Stale ack: ack_i=1 when req_i rises -> valid_o stays 0 until ack_i is low, then byte A5 appears.
- Abort: drop req_i after byte 5 is acked -> valid_o=0 within SYNC_STAGES+1 cycles and no frame_done_o. A new request restarts at byte A5.
- Reset mid-frame: assert rst_i while valid_o=1 at index 7 -> valid_o=0 asynchronously. The next request produces a complete frame from byte 0.
